imu_sample_sequencer: RTL and testbench

- Producer side of the IMU sample interface: periodically requests a 14-byte burst read of the IMU data registers (ACCEL_XOUT_H..GYRO_ZOUT_L) from the serial bus master.
- Assembles the returned bytes into big-endian signed 16-bit words and presents accel/gyro raw values with a one-cycle data_ready strobe to the tilt filter.
- Sits between the SPI/I2C bus master and the complementary filter; owns sample timing (dt) and bus-error detection.

---
 rtl/imu_sample_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_imu_sample_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : imu_sample_sequencer
// Brief    : Periodically requests a 14-byte IMU register burst from the bus
//            master, assembles big-endian signed words and publishes them to
//            the tilt filter with a one-cycle data_ready strobe. Tracks bus
//            timeouts and dropped sample ticks.
// Revision : 1.0 - initial release
// ============================================================================
module imu_sample_sequencer #(
    parameter int         SAMPLE_DIV = 8890,
    parameter int         TIMEOUT    = 4096,
    parameter logic [7:0] START_ADDR = 8'h3B,
    parameter int         BURST_LEN  = 14
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               enable,
    output logic               rd_req,
    output logic [7:0]         rd_addr,
    output logic [3:0]         rd_len,
    input  logic               rd_ack,
    input  logic               rx_valid,
    input  logic [7:0]         rx_byte,
    output logic signed [15:0] accel_x_raw,
    output logic signed [15:0] accel_y_raw,
    output logic signed [15:0] accel_z_raw,
    output logic signed [15:0] gyro_x_raw,
    output logic signed [15:0] gyro_y_raw,
    output logic signed [15:0] gyro_z_raw,
    output logic signed [15:0] temp_raw,
    output logic               data_ready,
    output logic               timeout_err,
    output logic               overrun,
    output logic [7:0]         err_count
);

    localparam logic [19:0] c_tick_last = 20'(SAMPLE_DIV - 1);
    // Abort is decided one cycle early so the strobe lands on the cycle the
    // timeout counter reaches TIMEOUT-1.
    localparam logic [15:0] c_to_last   = 16'(TIMEOUT - 2);
    localparam logic [3:0]  c_last_idx  = 4'(BURST_LEN - 1);
    localparam logic [3:0]  c_len       = 4'(BURST_LEN);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_req     = 2'd1;
    localparam logic [1:0] c_st_recv    = 2'd2;
    localparam logic [1:0] c_st_publish = 2'd3;

    logic [1:0]         r_state;
    logic [19:0]        r_tick_cnt;
    logic [15:0]        r_to_cnt;
    logic [3:0]         r_idx;
    logic [7:0]         r_shadow [0:BURST_LEN-2];
    logic               r_rd_req;
    logic [7:0]         r_rd_addr;
    logic [3:0]         r_rd_len;
    logic signed [15:0] r_accel_x;
    logic signed [15:0] r_accel_y;
    logic signed [15:0] r_accel_z;
    logic signed [15:0] r_gyro_x;
    logic signed [15:0] r_gyro_y;
    logic signed [15:0] r_gyro_z;
    logic signed [15:0] r_temp;
    logic               r_data_ready;
    logic               r_timeout_err;
    logic               r_overrun;
    logic [7:0]         r_err_count;

    logic               w_tick;

    assign w_tick = enable && (r_tick_cnt == c_tick_last);

    // Free-running sample period counter, parked at zero while disabled
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tick_cnt <= '0;
        end else if (!enable) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_tick_last) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 20'd1;
        end
    end

    // Burst sequencer: request, collect bytes into shadow, publish, or abort
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= c_st_idle;
            r_to_cnt      <= '0;
            r_idx         <= '0;
            for (int i = 0; i < BURST_LEN - 1; i++) begin
                r_shadow[i] <= '0;
            end
            r_rd_req      <= 1'b0;
            r_rd_addr     <= '0;
            r_rd_len      <= '0;
            r_accel_x     <= '0;
            r_accel_y     <= '0;
            r_accel_z     <= '0;
            r_gyro_x      <= '0;
            r_gyro_y      <= '0;
            r_gyro_z      <= '0;
            r_temp        <= '0;
            r_data_ready  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun     <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_data_ready  <= 1'b0;
            r_timeout_err <= 1'b0;
            // Any tick seen outside IDLE (including the PUBLISH exit cycle) is lost
            r_overrun     <= w_tick && (r_state != c_st_idle);

            case (r_state)
                c_st_idle: begin
                    if (w_tick) begin
                        r_state   <= c_st_req;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= START_ADDR;
                        r_rd_len  <= c_len;
                        r_to_cnt  <= '0;
                    end
                end

                c_st_req: begin
                    if (r_to_cnt == c_to_last) begin
                        r_state       <= c_st_idle;
                        r_rd_req      <= 1'b0;
                        r_rd_addr     <= '0;
                        r_rd_len      <= '0;
                        r_idx         <= '0;
                        r_timeout_err <= 1'b1;
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                        if (rd_ack) begin
                            r_state   <= c_st_recv;
                            r_idx     <= '0;
                            r_rd_req  <= 1'b0;
                            r_rd_addr <= '0;
                            r_rd_len  <= '0;
                        end
                    end
                end

                c_st_recv: begin
                    // Final byte has priority over a coincident timeout
                    if (rx_valid && (r_idx == c_last_idx)) begin
                        r_state      <= c_st_publish;
                        r_data_ready <= 1'b1;
                        r_idx        <= '0;
                        r_accel_x    <= {r_shadow[0],  r_shadow[1]};
                        r_accel_y    <= {r_shadow[2],  r_shadow[3]};
                        r_accel_z    <= {r_shadow[4],  r_shadow[5]};
                        r_temp       <= {r_shadow[6],  r_shadow[7]};
                        r_gyro_x     <= {r_shadow[8],  r_shadow[9]};
                        r_gyro_y     <= {r_shadow[10], r_shadow[11]};
                        r_gyro_z     <= {r_shadow[12], rx_byte};
                    end else if (r_to_cnt == c_to_last) begin
                        r_state       <= c_st_idle;
                        r_idx         <= '0;
                        r_timeout_err <= 1'b1;
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                        if (rx_valid) begin
                            r_shadow[r_idx] <= rx_byte;
                            r_idx           <= r_idx + 4'd1;
                        end
                    end
                end

                c_st_publish: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rd_req      = r_rd_req;
    assign rd_addr     = r_rd_addr;
    assign rd_len      = r_rd_len;
    assign accel_x_raw = r_accel_x;
    assign accel_y_raw = r_accel_y;
    assign accel_z_raw = r_accel_z;
    assign gyro_x_raw  = r_gyro_x;
    assign gyro_y_raw  = r_gyro_y;
    assign gyro_z_raw  = r_gyro_z;
    assign temp_raw    = r_temp;
    assign data_ready  = r_data_ready;
    assign timeout_err = r_timeout_err;
    assign overrun     = r_overrun;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imu_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_imu_sample_sequencer
// Brief    : Directed bench. Instance A (SAMPLE_DIV=64, TIMEOUT=4096) covers
//            normal bursts, periodicity, overrun and reset; instance B
//            (SAMPLE_DIV=64, TIMEOUT=32) covers timeouts and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imu_sample_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst, en_a, en_b, sel, ack, rxv;
    logic [7:0] rxb;
    logic       ack_a, ack_b, rxv_a, rxv_b;

    assign ack_a = ack && !sel;
    assign ack_b = ack && sel;
    assign rxv_a = rxv && !sel;
    assign rxv_b = rxv && sel;

    logic        req_a, req_b, dr_a, dr_b, te_a, te_b, ov_a, ov_b;
    logic [7:0]  addr_a, addr_b, ec_a, ec_b;
    logic [3:0]  len_a, len_b;
    logic [15:0] ax_a, ay_a, az_a, gx_a, gy_a, gz_a, tp_a;
    logic [15:0] ax_b, ay_b, az_b, gx_b, gy_b, gz_b, tp_b;

    imu_sample_sequencer #(.SAMPLE_DIV(64), .TIMEOUT(4096)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .enable(en_a),
        .rd_req(req_a), .rd_addr(addr_a), .rd_len(len_a), .rd_ack(ack_a),
        .rx_valid(rxv_a), .rx_byte(rxb),
        .accel_x_raw(ax_a), .accel_y_raw(ay_a), .accel_z_raw(az_a),
        .gyro_x_raw(gx_a), .gyro_y_raw(gy_a), .gyro_z_raw(gz_a), .temp_raw(tp_a),
        .data_ready(dr_a), .timeout_err(te_a), .overrun(ov_a), .err_count(ec_a)
    );

    imu_sample_sequencer #(.SAMPLE_DIV(64), .TIMEOUT(32)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .enable(en_b),
        .rd_req(req_b), .rd_addr(addr_b), .rd_len(len_b), .rd_ack(ack_b),
        .rx_valid(rxv_b), .rx_byte(rxb),
        .accel_x_raw(ax_b), .accel_y_raw(ay_b), .accel_z_raw(az_b),
        .gyro_x_raw(gx_b), .gyro_y_raw(gy_b), .gyro_z_raw(gz_b), .temp_raw(tp_b),
        .data_ready(dr_b), .timeout_err(te_b), .overrun(ov_b), .err_count(ec_b)
    );

    // Observation mux onto the instance currently selected
    logic        req, dr, te, ov;
    logic [7:0]  addr, ec;
    logic [3:0]  len;
    logic [15:0] ax, ay, az, gx, gy, gz, tp;
    assign req  = sel ? req_b  : req_a;
    assign dr   = sel ? dr_b   : dr_a;
    assign te   = sel ? te_b   : te_a;
    assign ov   = sel ? ov_b   : ov_a;
    assign addr = sel ? addr_b : addr_a;
    assign ec   = sel ? ec_b   : ec_a;
    assign len  = sel ? len_b  : len_a;
    assign ax   = sel ? ax_b   : ax_a;
    assign ay   = sel ? ay_b   : ay_a;
    assign az   = sel ? az_b   : az_a;
    assign gx   = sel ? gx_b   : gx_a;
    assign gy   = sel ? gy_b   : gy_a;
    assign gz   = sel ? gz_b   : gz_a;
    assign tp   = sel ? tp_b   : tp_a;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc_n = 0;
    int         t_last = 0;
    logic [7:0] pat [14];
    logic [15:0] ax_mid;
    logic        dr_mid;

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic set_pat_seq(input logic [7:0] base);
        for (int i = 0; i < 14; i++) pat[i] = base + 8'(i);
    endtask

    // Bounded wait for rd_req on the selected instance; t = cycle it was seen
    task automatic wait_req(input int max, output int t, output bit ok);
        int i;
        ok = 1'b0; t = 0; i = 0;
        while (!ok && i < max) begin
            cyc();
            i++;
            if (req) begin ok = 1'b1; t = cyc_n; end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL wait_req: rd_req not seen within %0d cycles", max);
        end
    endtask

    // Called in a cycle with rd_req high: ack, then one byte per cycle from pat.
    // Returns in the cycle after the last byte edge.
    task automatic serve(input int nbytes);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            if (i == nbytes - 1) begin ax_mid = ax; dr_mid = dr; end
            rxv = 1'b1;
            rxb = pat[i];
            cyc();
        end
        rxv = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; en_a = 1'b0; en_b = 1'b0; sel = 1'b0;
        ack = 1'b0; rxv = 1'b0; rxb = 8'h00;
        repeat (3) cyc();
        n_cmp++;
        if ({req_a, addr_a, len_a, dr_a, te_a, ov_a, ec_a} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctl_a: got %h want 0", {req_a, addr_a, len_a, dr_a, te_a, ov_a, ec_a});
        end
        n_cmp++;
        if ({ax_a, ay_a, az_a, tp_a, gx_a, gy_a, gz_a} !== '0) begin
            n_bad++;
            $display("FAIL reset_data_a: got %h want 0", {ax_a, ay_a, az_a, tp_a, gx_a, gy_a, gz_a});
        end
        n_cmp++;
        if ({req_b, ec_b, dr_b, ax_b, gz_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: got %h want 0", {req_b, ec_b, dr_b, ax_b, gz_b});
        end
        n_rst = 1'b1;
        cyc();
    endtask

    task automatic test_normal();
        int t_en, t;
        bit ok;
        sel = 1'b0;
        en_a = 1'b1;
        t_en = cyc_n;
        wait_req(200, t, ok);
        t_last = t;
        n_cmp++;
        if (t - t_en != 64) begin
            n_bad++;
            $display("FAIL first_req_delay: got %0d want 64", t - t_en);
        end
        n_cmp++;
        if (addr !== 8'h3B || len !== 4'd14) begin
            n_bad++;
            $display("FAIL req_addr_len: got %h/%0d want 3b/14", addr, len);
        end
        pat = '{8'h01, 8'h02, 8'hFF, 8'h38, 8'h40, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h7D, 8'hFF, 8'h83, 8'h12, 8'h34};
        serve(14);
        n_cmp++;
        if (ax_mid !== 16'h0000 || dr_mid !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_hidden: got ax=%h dr=%b want 0000/0", ax_mid, dr_mid);
        end
        n_cmp++;
        if (dr !== 1'b1) begin
            n_bad++;
            $display("FAIL data_ready_latency: got %b want 1", dr);
        end
        n_cmp++;
        if (ax !== 16'h0102 || ay !== 16'hFF38 || az !== 16'h4000) begin
            n_bad++;
            $display("FAIL accel_words: got %h %h %h want 0102 ff38 4000", ax, ay, az);
        end
        n_cmp++;
        if (tp !== 16'h0000) begin
            n_bad++;
            $display("FAIL temp_word: got %h want 0000", tp);
        end
        n_cmp++;
        if (gx !== 16'h007D || gy !== 16'hFF83 || gz !== 16'h1234) begin
            n_bad++;
            $display("FAIL gyro_words: got %h %h %h want 007d ff83 1234", gx, gy, gz);
        end
        n_cmp++;
        if (req !== 1'b0 || addr !== 8'h00 || len !== 4'd0) begin
            n_bad++;
            $display("FAIL req_idle_zero: got %b %h %0d want 0 00 0", req, addr, len);
        end
        cyc();
        n_cmp++;
        if (dr !== 1'b0 || ax !== 16'h0102 || gz !== 16'h1234) begin
            n_bad++;
            $display("FAIL hold_after_strobe: got dr=%b ax=%h gz=%h want 0 0102 1234", dr, ax, gz);
        end
    endtask

    task automatic test_periodicity();
        logic [15:0] exp_ax, exp_gz;
        logic [7:0]  base;
        int          extra, t, i;
        bit          stable, seen;
        sel = 1'b0;
        exp_ax = 16'h0102;
        exp_gz = 16'h1234;
        extra = 0;
        stable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0; i = 0; t = 0;
            while (!seen && i < 100) begin
                cyc();
                i++;
                if (dr) extra++;
                if (ax !== exp_ax || gz !== exp_gz) stable = 1'b0;
                if (req) begin seen = 1'b1; t = cyc_n; end
            end
            n_cmp++;
            if (!seen || t - t_last != 64) begin
                n_bad++;
                $display("FAIL period: got %0d want 64 (seen=%b)", t - t_last, seen);
            end
            t_last = t;
            base = 8'h20 * 8'(k + 1);
            set_pat_seq(base);
            serve(14);
            exp_ax = {base, base + 8'd1};
            exp_gz = {base + 8'd12, base + 8'd13};
            n_cmp++;
            if (dr !== 1'b1 || ax !== exp_ax || gz !== exp_gz) begin
                n_bad++;
                $display("FAIL periodic_sample: got dr=%b ax=%h gz=%h want 1 %h %h", dr, ax, gz, exp_ax, exp_gz);
            end
        end
        n_cmp++;
        if (extra != 0 || stable !== 1'b1) begin
            n_bad++;
            $display("FAIL between_strobes: got extra=%0d stable=%b want 0 1", extra, stable);
        end
    endtask

    task automatic test_overrun();
        int  t, t2, ov_cnt, ov_at;
        bit  ok, dropped;
        sel = 1'b0;
        wait_req(100, t, ok);
        ov_cnt = 0; ov_at = -1; dropped = 1'b0;
        for (int i = 0; i < 70; i++) begin
            cyc();
            if (!req) dropped = 1'b1;
            if (ov) begin ov_cnt++; ov_at = cyc_n - t; end
        end
        n_cmp++;
        if (ov_cnt != 1 || ov_at != 64) begin
            n_bad++;
            $display("FAIL overrun_pulse: got count=%0d at=%0d want 1 at 64", ov_cnt, ov_at);
        end
        n_cmp++;
        if (dropped !== 1'b0) begin
            n_bad++;
            $display("FAIL req_held: got dropped=%b want 0", dropped);
        end
        set_pat_seq(8'h90);
        serve(14);
        n_cmp++;
        if (dr !== 1'b1 || ax !== 16'h9091) begin
            n_bad++;
            $display("FAIL late_burst: got dr=%b ax=%h want 1 9091", dr, ax);
        end
        wait_req(100, t2, ok);
        n_cmp++;
        if (t2 - t != 128) begin
            n_bad++;
            $display("FAIL no_queued_req: got next req at +%0d want +128", t2 - t);
        end
    endtask

    task automatic test_reset_mid_recv();
        bit early, bad_dr;
        sel = 1'b0;
        set_pat_seq(8'hA0);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rxv = 1'b1; rxb = pat[i];
            cyc();
        end
        rxv = 1'b0;
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({ax_a, ay_a, az_a, tp_a, gx_a, gy_a, gz_a} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_data: got %h want 0", {ax_a, ay_a, az_a, tp_a, gx_a, gy_a, gz_a});
        end
        n_cmp++;
        if ({req_a, dr_a, ec_a, ov_a, te_a} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_ctl: got %h want 0", {req_a, dr_a, ec_a, ov_a, te_a});
        end
        cyc();
        cyc();
        n_rst = 1'b1;
        early = 1'b0; bad_dr = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            cyc();
            if (dr) bad_dr = 1'b1;
            if (k < 64 && req) early = 1'b1;
        end
        n_cmp++;
        if (req !== 1'b1 || early !== 1'b0) begin
            n_bad++;
            $display("FAIL resume_tick: got req@64=%b early=%b want 1 0", req, early);
        end
        n_cmp++;
        if (bad_dr !== 1'b0) begin
            n_bad++;
            $display("FAIL no_ready_after_reset: got %b want 0", bad_dr);
        end
        en_a = 1'b0;
    endtask

    task automatic test_timeout();
        int t, t3;
        bit ok, early;
        sel = 1'b1;
        en_b = 1'b1;
        wait_req(100, t, ok);
        set_pat_seq(8'h50);
        serve(14);
        n_cmp++;
        if (dr !== 1'b1 || ax !== 16'h5051) begin
            n_bad++;
            $display("FAIL b_first_burst: got dr=%b ax=%h want 1 5051", dr, ax);
        end
        wait_req(100, t, ok);
        set_pat_seq(8'hC0);
        serve(5);
        early = 1'b0;
        while (cyc_n < t + 31) begin
            cyc();
            if (cyc_n < t + 31 && te) early = 1'b1;
        end
        n_cmp++;
        if (te !== 1'b1 || early !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_at_31: got te=%b early=%b want 1 0", te, early);
        end
        n_cmp++;
        if (ec !== 8'd1) begin
            n_bad++;
            $display("FAIL err_count_1: got %0d want 1", ec);
        end
        n_cmp++;
        if (ax !== 16'h5051 || gz !== 16'h5C5D || dr !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_keeps_data: got ax=%h gz=%h dr=%b want 5051 5c5d 0", ax, gz, dr);
        end
        cyc();
        n_cmp++;
        if (te !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_one_cycle: got %b want 0", te);
        end
        wait_req(100, t3, ok);
        set_pat_seq(8'h60);
        serve(14);
        n_cmp++;
        if (dr !== 1'b1 || ax !== 16'h6061 || gz !== 16'h6C6D) begin
            n_bad++;
            $display("FAIL recover_burst: got dr=%b ax=%h gz=%h want 1 6061 6c6d", dr, ax, gz);
        end
    endtask

    task automatic test_boundary();
        int t;
        bit ok;
        sel = 1'b1;
        wait_req(100, t, ok);
        set_pat_seq(8'h70);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        while (cyc_n < t + 17) cyc();
        for (int i = 0; i < 14; i++) begin
            rxv = 1'b1; rxb = pat[i];
            cyc();
        end
        rxv = 1'b0;
        n_cmp++;
        if (dr !== 1'b1 || te !== 1'b0) begin
            n_bad++;
            $display("FAIL byte_beats_timeout: got dr=%b te=%b want 1 0", dr, te);
        end
        n_cmp++;
        if (gz !== 16'h7C7D || ec !== 8'd1) begin
            n_bad++;
            $display("FAIL boundary_data: got gz=%h ec=%0d want 7c7d 1", gz, ec);
        end
    endtask

    task automatic test_saturation();
        int         t, n;
        bit         ok;
        logic [7:0] exp_ec;
        sel = 1'b1;
        exp_ec = 8'd1;
        for (int i = 0; i < 300; i++) begin
            wait_req(100, t, ok);
            n = 0;
            while (!te && n < 40) begin cyc(); n++; end
            if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
            n_cmp++;
            if (te !== 1'b1 || ec !== exp_ec) begin
                n_bad++;
                $display("FAIL saturation[%0d]: got te=%b ec=%0d want 1 %0d", i, te, ec, exp_ec);
            end
        end
        n_cmp++;
        if (ec !== 8'd255) begin
            n_bad++;
            $display("FAIL err_count_sat: got %0d want 255", ec);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_periodicity();
        test_overrun();
        test_reset_mid_recv();
        test_timeout();
        test_boundary();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
